dsd_frame_scheduler: RTL and testbench
======================================

Name: dsd_frame_scheduler

Overview:
- Sequencing controller for the I2S-to-DSD datapath: receiver, three-stage interpolator and 512x modulator.
- Tracks the ws frame clock in the bclk domain and decides whether the frame structure is locked.
- Generates the frame-aligned rate strobes en_64, en_32, en_16 and en_8 that pace the datapath.
- Controls datapath flush and output mute so the modulator never runs on misaligned or partial samples.

Parameters:
- FRAME_LEN, 64: expected bclk cycles per ws period. Power of two, 16..128.
- LOCK_FRAMES, 4: consecutive correct-length frames needed to lock (1..15).
- LOSS_FRAMES, 2: consecutive bad frames while locked that drop lock (1..15).
- MUTE_FRAMES, 2: frames mute stays high after lock is reached (0..15).
- EN64_OFFSET, 0: fcnt value at which en_64 fires (0..FRAME_LEN-1).

Ports:
- bclk  in  1  bit clock; sole clock.
- rst  in  1  synchronous reset, active-high.
- ws  in  1  word select, already synchronous to bclk.
- en_64  out  1  strobe, 1 per frame.
- en_32  out  1  strobe, 2 per frame.
- en_16  out  1  strobe, 4 per frame.
- en_8  out  1  strobe, 8 per frame.
- dp_clr  out  1  one-cycle datapath flush pulse.
- mute  out  1  forces modulator input to zero when high.
- locked  out  1  high in state LOCKED.
- frame_err  out  1  one-cycle pulse on a bad-length frame or timeout.

Behaviour:
- Reset (rst high at a bclk edge) sets state=UNLOCKED, fcnt=0, good_cnt=0, bad_cnt=0, mute_cnt=0, ws_q=0.
- Output reset values: all en_* = 0, dp_clr = 0, frame_err = 0, locked = 0, mute = 1.
- Reset mid-operation aborts immediately, with no flush pulse.
- ws_q <= ws every cycle. edge = ws & ~ws_q.
- fcnt is 8 bits. On edge: fcnt <= 0. Otherwise fcnt <= fcnt+1, saturating at TMO = 2*FRAME_LEN-1.
- Measured length at an edge is fcnt+1. It is good iff it equals FRAME_LEN.
- Strobe decode comes only from registered fcnt and state (no combinational path from ws).
- Strobes are active only when state==LOCKED and fcnt < FRAME_LEN.
- en_64 = (fcnt == EN64_OFFSET).
- en_32 = (fcnt mod FRAME_LEN/2 == EN64_OFFSET mod FRAME_LEN/2).
- en_16 and en_8 are decoded the same way with moduli FRAME_LEN/4 and FRAME_LEN/8.
- Consequence: every en_64 coincides with en_32, en_16 and en_8.
- State UNLOCKED: on the first edge go to ACQUIRE with good_cnt=0. The length of that first edge is not checked.
- State ACQUIRE, good edge: good_cnt++. If good_cnt+1 == LOCK_FRAMES, go to LOCKED, pulse dp_clr in the cycle of the transition, and load mute_cnt=MUTE_FRAMES.
- State ACQUIRE, bad edge: good_cnt=0, frame_err pulse, stay in ACQUIRE.
- State LOCKED, good edge: bad_cnt=0. If mute_cnt>0, decrement it.
- State LOCKED, bad edge: frame_err pulse and bad_cnt++. If bad_cnt+1 == LOSS_FRAMES, go to UNLOCKED.
- Timeout: fcnt reaching TMO in ACQUIRE or LOCKED goes to UNLOCKED, pulses frame_err once and clears all counters. fcnt stays saturated until the next edge.
- dp_clr and frame_err are registered one-cycle pulses, asserted the cycle after the triggering edge or timeout.
- locked and mute are also registered, one cycle after the state change.
- mute = 1 unless state==LOCKED and mute_cnt==0.
- mute rises in the same cycle locked falls.
- Edge coincident with timeout: the edge wins (fcnt<=0, length judged as bad).

Test Plan:
- Clean ws, 64-cycle period, default parameters: locked rises one cycle after the 5th edge; dp_clr pulses once; mute falls after 2 further good frames.
- Same stimulus, count strobes per 64-cycle frame: exactly 1/2/4/8 pulses; en_64 at fcnt=0; en_8 at fcnt=0,8,..,56.
- In lock, inject one 63-cycle frame then good frames: one frame_err, locked stays high, bad_cnt clears. Two consecutive 65-cycle frames: locked falls, mute rises, strobes stop.
- During ACQUIRE after 3 good frames, inject a 62-cycle frame: frame_err, good_cnt resets, lock needs 4 new good frames (locked after the 4th).
- Hold ws low while locked: after fcnt reaches 127, frame_err pulses exactly once, state UNLOCKED, no further strobes; re-lock once ws resumes.
- Assert rst for one cycle while locked and mid-frame: next cycle all outputs are at reset values with mute=1; recovery follows the normal acquire sequence.

Source files
------------

// File: rtl/dsd_frame_scheduler_if.sv
// Frame-scheduler bundle: ws in, rate strobes and datapath
// sequencing controls out.
interface dsd_frame_scheduler_if;
    logic ws;
    logic en_64;
    logic en_32;
    logic en_16;
    logic en_8;
    logic dp_clr;
    logic mute;
    logic locked;
    logic frame_err;

    modport master (
        output ws,
        input  en_64,
        input  en_32,
        input  en_16,
        input  en_8,
        input  dp_clr,
        input  mute,
        input  locked,
        input  frame_err
    );

    modport slave (
        input  ws,
        output en_64,
        output en_32,
        output en_16,
        output en_8,
        output dp_clr,
        output mute,
        output locked,
        output frame_err
    );
endinterface

// File: rtl/dsd_frame_scheduler.sv
// Frame lock tracker and rate-strobe generator pacing the
// I2S-to-DSD receiver, interpolator and modulator.
module dsd_frame_scheduler #(
    parameter int FRAME_LEN   = 64,
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 2,
    parameter int MUTE_FRAMES = 2,
    parameter int EN64_OFFSET = 0
) (
    input  logic                 bclk,
    input  logic                 rst,
    dsd_frame_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_e;

    localparam logic [7:0] FL     = 8'(FRAME_LEN);
    localparam logic [7:0] TMO    = 8'(2 * FRAME_LEN - 1);
    localparam logic [7:0] OFF    = 8'(EN64_OFFSET);
    localparam logic [7:0] M32    = 8'(FRAME_LEN / 2 - 1);
    localparam logic [7:0] M16    = 8'(FRAME_LEN / 4 - 1);
    localparam logic [7:0] M8     = 8'(FRAME_LEN / 8 - 1);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [3:0] LOSS_N = 4'(LOSS_FRAMES);
    localparam logic [3:0] MUTE_N = 4'(MUTE_FRAMES);

    state_e     state_q;
    logic       ws_q;
    logic [7:0] fcnt_q;
    logic [7:0] fcnt_d;
    logic [3:0] good_cnt_q;
    logic [3:0] bad_cnt_q;
    logic [3:0] mute_cnt_q;
    logic       dp_clr_q;
    logic       frame_err_q;
    logic       locked_q;
    logic       mute_q;

    logic       ws_rise;
    logic       len_ok;
    logic       tmo_hit;
    logic       lock_hit;
    logic       loss_hit;
    logic       in_win;

    always_comb begin
        ws_rise  = bus.ws & ~ws_q;
        len_ok   = (fcnt_q == FL - 8'd1);
        tmo_hit  = !ws_rise && (fcnt_q == TMO)
                   && (state_q != ST_UNLOCKED);
        lock_hit = ((good_cnt_q + 4'd1) == LOCK_N);
        loss_hit = ((bad_cnt_q + 4'd1) == LOSS_N);
        // Counter parks at TMO so a dead ws cannot wrap into a fake frame.
        if (ws_rise) begin
            fcnt_d = '0;
        end else if (fcnt_q == TMO) begin
            fcnt_d = TMO;
        end else begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            ws_q        <= 1'b0;
            fcnt_q      <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            mute_cnt_q  <= '0;
            dp_clr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            mute_q      <= 1'b1;
        end else begin
            ws_q        <= bus.ws;
            fcnt_q      <= fcnt_d;
            dp_clr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (ws_rise) begin
                        state_q    <= ST_ACQUIRE;
                        good_cnt_q <= '0;
                        bad_cnt_q  <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (ws_rise && len_ok && lock_hit) begin
                        state_q    <= ST_LOCKED;
                        good_cnt_q <= '0;
                        bad_cnt_q  <= '0;
                        mute_cnt_q <= MUTE_N;
                        dp_clr_q   <= 1'b1;
                        locked_q   <= 1'b1;
                        mute_q     <= (MUTE_N != 4'd0);
                    end else if (ws_rise && len_ok) begin
                        good_cnt_q <= good_cnt_q + 4'd1;
                    end else if (ws_rise) begin
                        good_cnt_q  <= '0;
                        frame_err_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q     <= ST_UNLOCKED;
                        good_cnt_q  <= '0;
                        bad_cnt_q   <= '0;
                        mute_cnt_q  <= '0;
                        frame_err_q <= 1'b1;
                        locked_q    <= 1'b0;
                        mute_q      <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (ws_rise && len_ok) begin
                        bad_cnt_q <= '0;
                        if (mute_cnt_q != 4'd0) begin
                            mute_cnt_q <= mute_cnt_q - 4'd1;
                        end
                        mute_q <= (mute_cnt_q > 4'd1);
                    end else if ((ws_rise && loss_hit) || tmo_hit) begin
                        state_q     <= ST_UNLOCKED;
                        good_cnt_q  <= '0;
                        bad_cnt_q   <= '0;
                        mute_cnt_q  <= '0;
                        frame_err_q <= 1'b1;
                        locked_q    <= 1'b0;
                        mute_q      <= 1'b1;
                    end else if (ws_rise) begin
                        bad_cnt_q   <= bad_cnt_q + 4'd1;
                        frame_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_UNLOCKED;
                    locked_q <= 1'b0;
                    mute_q   <= 1'b1;
                end
            endcase
        end
    end

    // Strobes decode registered state only; the fcnt window keeps
    // an over-long frame from emitting extra pulses.
    assign in_win = (state_q == ST_LOCKED) && (fcnt_q < FL);

    assign bus.en_64 = in_win && (fcnt_q == OFF);
    assign bus.en_32 = in_win && ((fcnt_q & M32) == (OFF & M32));
    assign bus.en_16 = in_win && ((fcnt_q & M16) == (OFF & M16));
    assign bus.en_8  = in_win && ((fcnt_q & M8) == (OFF & M8));

    assign bus.dp_clr    = dp_clr_q;
    assign bus.frame_err = frame_err_q;
    assign bus.locked    = locked_q;
    assign bus.mute      = mute_q;

endmodule

// File: tb/tb_dsd_frame_scheduler.sv
// Directed frame-sequence bench for dsd_frame_scheduler with
// hand-computed per-frame expectations.
module tb_dsd_frame_scheduler;

    typedef struct {
        int len;
        int lock;
        int mute;
        int err;
        int clr;
        int n64;
        int n32;
        int n16;
        int n8;
    } vec_t;

    logic bclk = 1'b0;
    logic rst  = 1'b1;

    dsd_frame_scheduler_if bus ();

    dsd_frame_scheduler dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 bclk = ~bclk;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[36];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input int lock,
                                input int mute, input int err,
                                input int clr, input int full);
        vec_t v;
        v.len  = len;
        v.lock = lock;
        v.mute = mute;
        v.err  = err;
        v.clr  = clr;
        v.n64  = full ? 1 : 0;
        v.n32  = full ? 2 : 0;
        v.n16  = full ? 4 : 0;
        v.n8   = full ? 8 : 0;
        return v;
    endfunction

    // One ws period starting with a rising edge; outputs judged at c=0
    // reflect the frame that just ended, strobe counts cover this one.
    task automatic run_vec(input int idx);
        vec_t v;
        int lk, mt, er, cl, a, b, c2, d, bad_pos;
        v = tbl[idx];
        lk = 0; mt = 0; er = 0; cl = 0;
        a = 0; b = 0; c2 = 0; d = 0; bad_pos = 0;
        for (int c = 0; c < v.len; c++) begin
            bus.ws = (c < v.len / 2);
            @(negedge bclk);
            if (c == 0) begin
                lk = int'(bus.locked);
                mt = int'(bus.mute);
            end
            er += int'(bus.frame_err);
            cl += int'(bus.dp_clr);
            a  += int'(bus.en_64);
            b  += int'(bus.en_32);
            c2 += int'(bus.en_16);
            d  += int'(bus.en_8);
            if ((bus.en_64 && c != 0) || (bus.en_32 && c % 32 != 0) ||
                (bus.en_16 && c % 16 != 0) || (bus.en_8 && c % 8 != 0))
                bad_pos++;
            if (bus.en_64 && !(bus.en_32 && bus.en_16 && bus.en_8))
                bad_pos++;
        end
        chk($sformatf("v%0d.locked", idx), lk, v.lock);
        chk($sformatf("v%0d.mute", idx), mt, v.mute);
        chk($sformatf("v%0d.frame_err", idx), er, v.err);
        chk($sformatf("v%0d.dp_clr", idx), cl, v.clr);
        chk($sformatf("v%0d.en_64", idx), a, v.n64);
        chk($sformatf("v%0d.en_32", idx), b, v.n32);
        chk($sformatf("v%0d.en_16", idx), c2, v.n16);
        chk($sformatf("v%0d.en_8", idx), d, v.n8);
        chk($sformatf("v%0d.strobe_pos", idx), bad_pos, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".en_64"}, int'(bus.en_64), 0);
        chk({nm, ".en_32"}, int'(bus.en_32), 0);
        chk({nm, ".en_16"}, int'(bus.en_16), 0);
        chk({nm, ".en_8"}, int'(bus.en_8), 0);
        chk({nm, ".dp_clr"}, int'(bus.dp_clr), 0);
        chk({nm, ".frame_err"}, int'(bus.frame_err), 0);
        chk({nm, ".locked"}, int'(bus.locked), 0);
        chk({nm, ".mute"}, int'(bus.mute), 1);
    endtask

    initial begin
        int errs, first, strb, lk64;

        // clean acquisition and lock
        tbl[0]  = mk(64, 0, 1, 0, 0, 0);
        tbl[1]  = mk(64, 0, 1, 0, 0, 0);
        tbl[2]  = mk(64, 0, 1, 0, 0, 0);
        tbl[3]  = mk(64, 0, 1, 0, 0, 0);
        tbl[4]  = mk(64, 1, 1, 0, 1, 1);
        tbl[5]  = mk(64, 1, 1, 0, 0, 1);
        tbl[6]  = mk(64, 1, 0, 0, 0, 1);
        // short frame, then two long frames dropping lock
        tbl[7]  = mk(63, 1, 0, 0, 0, 1);
        tbl[8]  = mk(64, 1, 0, 1, 0, 1);
        tbl[9]  = mk(64, 1, 0, 0, 0, 1);
        tbl[10] = mk(65, 1, 0, 0, 0, 1);
        tbl[11] = mk(65, 1, 0, 1, 0, 1);
        tbl[12] = mk(64, 0, 1, 1, 0, 0);
        // acquire, bad frame after 3 good, re-acquire
        tbl[13] = mk(64, 0, 1, 0, 0, 0);
        tbl[14] = mk(64, 0, 1, 0, 0, 0);
        tbl[15] = mk(64, 0, 1, 0, 0, 0);
        tbl[16] = mk(62, 0, 1, 0, 0, 0);
        tbl[17] = mk(64, 0, 1, 1, 0, 0);
        tbl[18] = mk(64, 0, 1, 0, 0, 0);
        tbl[19] = mk(64, 0, 1, 0, 0, 0);
        tbl[20] = mk(64, 0, 1, 0, 0, 0);
        tbl[21] = mk(64, 1, 1, 0, 1, 1);
        tbl[22] = mk(64, 1, 1, 0, 0, 1);
        tbl[23] = mk(64, 1, 0, 0, 0, 1);
        // re-lock after timeout
        tbl[24] = mk(64, 0, 1, 0, 0, 0);
        tbl[25] = mk(64, 0, 1, 0, 0, 0);
        tbl[26] = mk(64, 0, 1, 0, 0, 0);
        tbl[27] = mk(64, 0, 1, 0, 0, 0);
        tbl[28] = mk(64, 1, 1, 0, 1, 1);
        // recovery after reset
        tbl[29] = mk(64, 0, 1, 0, 0, 0);
        tbl[30] = mk(64, 0, 1, 0, 0, 0);
        tbl[31] = mk(64, 0, 1, 0, 0, 0);
        tbl[32] = mk(64, 0, 1, 0, 0, 0);
        tbl[33] = mk(64, 1, 1, 0, 1, 1);
        tbl[34] = mk(64, 1, 1, 0, 0, 1);
        tbl[35] = mk(64, 1, 0, 0, 0, 1);

        bus.ws = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge bclk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i <= 23; i++) run_vec(i);

        // ws stuck low while locked: single timeout at fcnt=127
        bus.ws = 1'b0;
        errs = 0; first = -1; strb = 0; lk64 = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge bclk);
            if (bus.frame_err) begin
                errs++;
                if (first < 0) first = k;
            end
            strb += int'(bus.en_64 | bus.en_32 | bus.en_16 | bus.en_8);
            if (k == 64) lk64 = int'(bus.locked);
        end
        chk("tmo.err_count", errs, 1);
        chk("tmo.err_cycle", first, 65);
        chk("tmo.strobes", strb, 0);
        chk("tmo.locked_before", lk64, 1);
        chk("tmo.locked_after", int'(bus.locked), 0);
        chk("tmo.mute_after", int'(bus.mute), 1);

        for (int i = 24; i <= 28; i++) run_vec(i);

        // reset mid-frame where en_8 would otherwise fire (fcnt=24)
        for (int c = 0; c < 24; c++) begin
            bus.ws = (c < 32);
            @(negedge bclk);
        end
        chk("pre_rst.locked", int'(bus.locked), 1);
        bus.ws = 1'b0;
        rst = 1'b1;
        @(negedge bclk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        errs = 0;
        repeat (4) begin
            @(negedge bclk);
            errs += int'(bus.dp_clr) + int'(bus.locked);
        end
        chk("post_rst.quiet", errs, 0);

        for (int i = 29; i <= 35; i++) run_vec(i);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
